// File: rtl/mux_rr_stream.sv
// Round-robin N-channel stream multiplexer with a single registered output slot.
// Optional packet lock enabled by defining MUX_LOCK_EN.
module mux_rr_stream #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      I_clk,
  input  logic                      I_reset,
  input  logic [CHANNELS*WIDTH-1:0] I_data,
  input  logic [CHANNELS-1:0]       I_valid,
  input  logic [CHANNELS-1:0]       I_last,
  output logic [CHANNELS-1:0]       O_ready,
  output logic [WIDTH-1:0]          O_data,
  output logic                      O_valid,
  output logic                      O_last,
  output logic [SELW-1:0]           O_sel,
  input  logic                      I_ready,
  output logic                      O_dbg_state
);

  // Handshake: a word moves across any valid/ready pair exactly on a rising
  // edge where both are high; valid never waits on ready, and ready is only
  // offered to the arbitration winner when the output slot can take a word.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q;
  logic [WIDTH-1:0]  ch_data [CHANNELS];
  logic              grant_found;
  logic [SELW-1:0]   grant_idx;
  logic [SELW:0]     sum;
  logic [SELW-1:0]   idx;
  logic [SELW-1:0]   ptr_next;
  logic              slot_free;
  logic              xfer;

`ifdef MUX_LOCK_EN
  logic              locked_q;
  logic [SELW-1:0]   lock_ch_q;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_data[i] = I_data[i*WIDTH +: WIDTH];
    end
  end

  // First valid channel searching upward from ptr, wrapping at CHANNELS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum = {1'b0, ptr_q} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(CHANNELS)) begin
        sum = sum - (SELW+1)'(CHANNELS);
      end
      idx = sum[SELW-1:0];
      if (!grant_found && I_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
`ifdef MUX_LOCK_EN
    if (locked_q) begin
      grant_found = I_valid[lock_ch_q];
      grant_idx   = lock_ch_q;
    end
`endif
  end

  assign slot_free = (state_q == EMPTY) || I_ready;
  assign xfer      = grant_found && slot_free && !I_reset;
  assign ptr_next  = (grant_idx == SELW'(CHANNELS-1)) ? '0 : grant_idx + SELW'(1);

  always_comb begin
    O_ready = '0;
    if (xfer) begin
      O_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (I_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= EMPTY;
      O_data  <= '0;
      O_last  <= 1'b0;
      O_sel   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        O_data <= ch_data[grant_idx];
        O_last <= I_last[grant_idx];
        O_sel  <= grant_idx;
      end
    end
  end

`ifdef MUX_LOCK_EN
  // A packet in flight pins the grant; ptr only moves once the packet ends.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      ptr_q     <= '0;
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer) begin
      if (!I_last[grant_idx]) begin
        locked_q  <= 1'b1;
        lock_ch_q <= grant_idx;
      end else begin
        locked_q  <= 1'b0;
        ptr_q     <= ptr_next;
      end
    end
  end
`else
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_next;
    end
  end
`endif

  assign O_valid     = (state_q == FULL);
  assign O_dbg_state = state_q;

endmodule
